// File: rtl/tick_debouncer.sv
// Debounces N_BTN raw buttons against an external tick strobe; emits level, press and release.
// Optional macro AUTOREPEAT_EN adds repeated press pulses while a button stays held.

module tick_debouncer #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_TICKS - 1);

    if (STABLE_TICKS < 2 || STABLE_TICKS > 255 ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_RATE  < 1 || REPEAT_RATE  > 255) begin : g_bad_cfg
        $error("tick_debouncer: parameter out of legal range");
    end

    logic [N_BTN-1:0] sync_1;
    logic [N_BTN-1:0] sync_2;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [7:0]       cnt_q   [N_BTN];
    logic [7:0]       cnt_d   [N_BTN];
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_d;

`ifdef AUTOREPEAT_EN
    localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RATE_LAST  = 8'(REPEAT_RATE - 1);

    logic [7:0]       rep_q [N_BTN];
    logic [7:0]       rep_d [N_BTN];
    logic [N_BTN-1:0] rpt_q;
    logic [N_BTN-1:0] rpt_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef AUTOREPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
`ifdef AUTOREPEAT_EN
            rpt_q       <= '0;
`endif
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef AUTOREPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
`ifdef AUTOREPEAT_EN
            rpt_q       <= rpt_d;
`endif
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    // A level change on the synchronized input always aborts a wait before any tick is counted.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = btn_level[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
`ifdef AUTOREPEAT_EN
            rep_d[i] = rep_q[i];
            rpt_d[i] = rpt_q[i];
            if (state_q[i] != HELD) begin
                rep_d[i] = '0;
                rpt_d[i] = 1'b0;
            end
`endif
            case (state_q[i])
                IDLE: begin
                    if (sync_2[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_2[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == STABLE_LAST) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                HELD: begin
                    if (!sync_2[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
`ifdef AUTOREPEAT_EN
                        rep_d[i]   = '0;
                        rpt_d[i]   = 1'b0;
                    end else if (tick) begin
                        if (rep_q[i] == (rpt_q[i] ? RATE_LAST : DELAY_LAST)) begin
                            press_d[i] = 1'b1;
                            rep_d[i]   = '0;
                            rpt_d[i]   = 1'b1;
                        end else begin
                            rep_d[i] = rep_q[i] + 8'd1;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_2[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (tick) begin
                        if (cnt_q[i] == STABLE_LAST) begin
                            state_d[i]   = IDLE;
                            cnt_d[i]     = '0;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench for tick_debouncer: a run-length model of the debounce rules is compared every cycle.
// Define AUTOREPEAT_EN for both RTL and bench to exercise the auto-repeat path.

module tb_tick_debouncer;

    localparam int N_BTN        = 2;
    localparam int STABLE_TICKS = 4;
    localparam int REPEAT_DELAY = 3;
    localparam int REPEAT_RATE  = 2;

    logic             clk;
    logic             reset_n;
    logic             tick;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    int n_checks;
    int n_fail;
    int press_seen [N_BTN];
    int rel_seen   [N_BTN];
    int phase;
    int base;

    // Model: the raw pin reaches the debouncer two clocks late; a tick counts toward a change
    // only when the input already differed from the accepted level on the previous clock too.
    logic [N_BTN-1:0] hist_1;
    logic [N_BTN-1:0] hist_2;
    logic [N_BTN-1:0] prev_s;
    logic [N_BTN-1:0] m_level;
    logic [N_BTN-1:0] m_press;
    logic [N_BTN-1:0] m_rel;
    logic [N_BTN-1:0] rep_started;
    int               run_len [N_BTN];
    int               rep_len [N_BTN];

    tick_debouncer #(
        .N_BTN       (N_BTN),
        .STABLE_TICKS(STABLE_TICKS),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        hist_1      = '0;
        hist_2      = '0;
        prev_s      = '0;
        m_level     = '0;
        m_press     = '0;
        m_rel       = '0;
        rep_started = '0;
        for (int c = 0; c < N_BTN; c++) begin
            run_len[c] = 0;
            rep_len[c] = 0;
        end
    endtask

    task automatic model_update();
        logic [N_BTN-1:0] s;
`ifdef AUTOREPEAT_EN
        logic was_held;
`endif
        s      = hist_2;
        hist_2 = hist_1;
        hist_1 = btn_raw;
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < N_BTN; c++) begin
`ifdef AUTOREPEAT_EN
            was_held = m_level[c];
`endif
            if (s[c] != m_level[c]) begin
                if (s[c] != prev_s[c]) begin
                    run_len[c] = 0;
                end else if (tick) begin
                    run_len[c]++;
                    if (run_len[c] == STABLE_TICKS) begin
                        m_level[c] = s[c];
                        run_len[c] = 0;
                        if (s[c]) m_press[c] = 1'b1;
                        else      m_rel[c]   = 1'b1;
                    end
                end
            end else begin
                run_len[c] = 0;
            end
`ifdef AUTOREPEAT_EN
            if (was_held && s[c] && prev_s[c]) begin
                if (tick) begin
                    rep_len[c]++;
                    if (rep_len[c] == (rep_started[c] ? REPEAT_RATE : REPEAT_DELAY)) begin
                        m_press[c]     = 1'b1;
                        rep_len[c]     = 0;
                        rep_started[c] = 1'b1;
                    end
                end
            end else begin
                rep_len[c]     = 0;
                rep_started[c] = 1'b0;
            end
`endif
        end
        prev_s = s;
    endtask

    // One clock with the given inputs; the model steps on the edge, outputs are compared on the falling edge.
    task automatic apply_stimulus(input logic [N_BTN-1:0] raw, input logic tk);
        btn_raw = raw;
        tick    = tk;
        @(posedge clk);
        if (!reset_n) model_clear();
        else          model_update();
        @(negedge clk);
        check_output("level",   32'(btn_level),   32'(m_level));
        check_output("press",   32'(btn_press),   32'(m_press));
        check_output("release", 32'(btn_release), 32'(m_rel));
        for (int c = 0; c < N_BTN; c++) begin
            if (btn_press[c])   press_seen[c]++;
            if (btn_release[c]) rel_seen[c]++;
        end
    endtask

    task automatic run_cycles(input logic [N_BTN-1:0] raw, input int n);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(raw, phase == 9);
            phase = (phase + 1) % 10;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        phase    = 0;
        reset_n  = 1'b0;
        btn_raw  = '0;
        tick     = 1'b0;
        for (int c = 0; c < N_BTN; c++) begin
            press_seen[c] = 0;
            rel_seen[c]   = 0;
        end
        model_clear();
        @(negedge clk);

        repeat (3) apply_stimulus(2'b11, 1'b1);
        check_output("reset_level",   32'(btn_level),   32'd0);
        check_output("reset_press",   32'(btn_press),   32'd0);
        check_output("reset_release", 32'(btn_release), 32'd0);
        btn_raw = '0;
        reset_n = 1'b1;
        repeat (4) apply_stimulus(2'b00, 1'b0);

        // Clean press: tick held high continuously, so ticks on edges 4..7 are the counted ones.
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(2'b01, 1'b1);
            if (k == 6) check_output("press_too_early", 32'(btn_press), 32'd0);
        end
        check_output("press_accept", 32'(btn_press), 32'h1);
        check_output("level_accept", 32'(btn_level), 32'h1);
        apply_stimulus(2'b01, 1'b0);
        check_output("press_one_clk", 32'(btn_press), 32'd0);
        run_cycles(2'b01, 100);
`ifndef AUTOREPEAT_EN
        check_output("press_count_hold", 32'(press_seen[0]), 32'd1);
`endif
        check_output("ch1_quiet", 32'(press_seen[1] + rel_seen[1]), 32'd0);

        // Release glitch while held, then a real release.
        base = rel_seen[0];
        run_cycles(2'b00, 20);
        run_cycles(2'b01, 40);
        check_output("glitch_no_release", 32'(rel_seen[0] - base), 32'd0);
        check_output("glitch_level", 32'(btn_level), 32'h1);
        run_cycles(2'b00, 60);
        check_output("release_once", 32'(rel_seen[0] - base), 32'd1);
        check_output("release_level", 32'(btn_level), 32'd0);

        // Bounce: 15-clk toggles never stay long enough for four counted ticks.
        base = press_seen[0];
        for (int i = 0; i < 14; i++) run_cycles((i % 2 == 0) ? 2'b01 : 2'b00, 15);
        run_cycles(2'b00, 60);
        check_output("bounce_no_press", 32'(press_seen[0] - base), 32'd0);
        check_output("bounce_level", 32'(btn_level), 32'd0);

        // Coincident abort: three ticks counted, then the input drops on the same clock as the fourth tick.
        base = press_seen[0];
        repeat (3) apply_stimulus(2'b01, 1'b0);
        repeat (3) apply_stimulus(2'b01, 1'b1);
        repeat (2) apply_stimulus(2'b00, 1'b0);
        apply_stimulus(2'b00, 1'b1);
        repeat (5) apply_stimulus(2'b00, 1'b0);
        check_output("abort_no_press", 32'(press_seen[0] - base), 32'd0);
        check_output("abort_level", 32'(btn_level), 32'd0);

        // Both channels pressed together, then reset dropped between clock edges.
        run_cycles(2'b11, 60);
        check_output("both_held", 32'(btn_level), 32'h3);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_output("async_reset_level",   32'(btn_level),   32'd0);
        check_output("async_reset_press",   32'(btn_press),   32'd0);
        check_output("async_reset_release", 32'(btn_release), 32'd0);
        base = rel_seen[0] + rel_seen[1];
        repeat (3) apply_stimulus(2'b00, 1'b1);
        reset_n = 1'b1;
        run_cycles(2'b00, 40);
        check_output("no_release_after_reset", 32'(rel_seen[0] + rel_seen[1] - base), 32'd0);
        check_output("level_after_reset", 32'(btn_level), 32'd0);

`ifdef AUTOREPEAT_EN
        // Auto-repeat: presses at accept, then after held ticks 3, 5, 7, 9 and 11.
        base = press_seen[0];
        repeat (3) apply_stimulus(2'b01, 1'b0);
        repeat (4) apply_stimulus(2'b01, 1'b1);
        check_output("repeat_accept", 32'(press_seen[0] - base), 32'd1);
        for (int t = 1; t <= 12; t++) begin
            apply_stimulus(2'b01, 1'b1);
            if (t == 2) check_output("repeat_not_early", 32'(press_seen[0] - base), 32'd1);
            repeat (2) apply_stimulus(2'b01, 1'b0);
        end
        check_output("repeat_total", 32'(press_seen[0] - base), 32'd6);
        run_cycles(2'b00, 60);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Consumer end of the periodic tick-strobe interface used across the calculator: takes a 1-clk `tick` pulse (every n clocks) as its time base.
- Debounces N_BTN raw push-button/keypad inputs.
- Emits a clean held level plus 1-clk press and release pulses per button to the calculator control FSM.
- Sits between the board I/O pins and the operand/operator entry logic.

Parameters:
- N_BTN, 4: number of independent button channels.
- STABLE_TICKS, 4: consecutive ticks an input must stay at its new level before the change is accepted (legal 2..255).
- REPEAT_DELAY, 50: ticks held before the first auto-repeat pulse (AUTOREPEAT_EN only; legal 1..255).
- REPEAT_RATE, 10: ticks between subsequent auto-repeat pulses (AUTOREPEAT_EN only; legal 1..255).

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- tick, input, 1: 1-clk time-base strobe from the tick generator; ignored while reset_n=0.
- btn_raw, input, N_BTN: asynchronous raw buttons, active-high (1 = pressed).
- btn_level, output, N_BTN: debounced level per button.
- btn_press, output, N_BTN: 1-clk pulse per accepted press (and per auto-repeat).
- btn_release, output, N_BTN: 1-clk pulse per accepted release.

Behaviour:
- Reset: reset_n=0 asynchronously clears everything.
  - Synchronizers, counters and outputs go to 0; every FSM goes to IDLE.
  - No pulses are emitted during reset or on the first clock after release.
- Synchronization: each btn_raw bit passes through a 2-flop synchronizer (reset 0). `s` below is the synchronized bit.
- Each channel has an independent FSM with an 8-bit tick counter `cnt`. States:
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: s=0 -> IDLE, cnt=0 (bounce rejected). Otherwise each tick increments cnt. On the tick where cnt==STABLE_TICKS-1 with s=1 -> HELD, btn_level=1, btn_press=1 for exactly one clk.
  - HELD (level 1): s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: s=1 -> HELD, cnt=0, no pulse. Otherwise each tick increments cnt. On the tick where cnt==STABLE_TICKS-1 with s=0 -> IDLE, btn_level=0, btn_release=1 for one clk.
- Simultaneous s change and tick in a WAIT state: the abort (return to the previous stable state) wins and the tick is discarded.
- Counting: cnt advances only on cycles with tick=1. Cycles without tick hold cnt.
- Latency: a clean edge is accepted STABLE_TICKS ticks after it reaches `s`. The first of those ticks can occur no earlier than 2 clk after the raw edge.
  - Outputs are registered; the pulse appears the clk after the accepting tick edge.
- tick held high for consecutive clocks: each high cycle counts as one tick (documented misuse, no error flag).
- Channels never interact. Any number of channels may pulse in the same cycle.
- cnt saturates: it never wraps, because the transition happens at STABLE_TICKS-1.
- Reset asserted mid-WAIT or mid-HELD: return to IDLE with no release pulse.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - HELD owns a second 8-bit repeat counter, cleared on entry to HELD.
  - After REPEAT_DELAY ticks in HELD, an extra btn_press pulse is emitted.
  - Thereafter one btn_press pulse is emitted every REPEAT_RATE ticks while still in HELD.
  - Leaving HELD (to RELEASE_WAIT) clears the repeat counter. Returning to HELD from RELEASE_WAIT restarts REPEAT_DELAY.
- Undefined: repeat logic absent; exactly one btn_press per accepted press.
- REPEAT_* parameters are unused when the macro is undefined.

Test Plan:
- Clean press:
  - Setup: N_BTN=2, STABLE_TICKS=4, tick every 10 clk; raise btn_raw[0] and hold.
  - Required: btn_press[0] high exactly 1 clk, 4 ticks after sync; btn_level[0]=1; channel 1 outputs all 0.
- Bounce rejection: toggle btn_raw[0] 1/0 every 15 clk for 200 clk, then settle at 0 -> no btn_press and no btn_level change.
- Release glitch in HELD:
  - Stimulus: drop btn_raw[0] to 0 for 2 ticks, then back to 1.
  - Required: no btn_release; btn_level stays 1.
  - Then release for 4+ ticks -> single btn_release pulse; btn_level=0.
- Coincident abort: deassert s on the same clk as tick in PRESS_WAIT -> FSM to IDLE; cnt=0; no press.
- Reset mid-HELD: assert reset_n=0 asynchronously between clock edges -> all outputs 0 immediately; no release pulse after deassertion.
- AUTOREPEAT_EN with REPEAT_DELAY=3, REPEAT_RATE=2: hold 12 ticks after accept -> presses at accept, +3, +5, +7, +9, +11 ticks.
